// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: restoring shift-subtract, one quotient bit per cycle,
// truncation toward zero with saturation, valid/ready on both sides.
module fixed_point_divider #(
    parameter int M = 7,
    parameter int Q = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M+Q:0] dividend,
    input  logic [M+Q:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M+Q:0] quotient,
    output logic         overflow,
    output logic         div_by_zero
);
    localparam int W  = M + Q + 1;
    localparam int NW = W + Q;
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [NW-1:0]   num;
    logic [NW-1:0]   qacc;
    logic [W:0]      rem;
    logic [W-1:0]    dvs;
    logic            neg;
    logic            dz;
    logic            dvd_neg;
    logic [W:0]      shifted;
    logic [W:0]      diff;
    logic            ge;

    // Magnitude as unsigned W bits; the most-negative input maps to 2^(W-1).
    function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
        logic [W-1:0] u;
        u = v;
        return v[W-1] ? (~u + 1'b1) : u;
    endfunction

    // Returns {overflow, signed result} from sign and the raw unsigned quotient magnitude.
    function automatic logic [W:0] saturate(input logic n, input logic [NW-1:0] m);
        logic [NW-1:0] maxp;
        logic [NW-1:0] maxn;
        maxp = {{(Q+1){1'b0}}, {(W-1){1'b1}}};
        maxn = maxp + 1'b1;
        if (!n) begin
            if (m > maxp) return {1'b1, 1'b0, {(W-1){1'b1}}};
            return {1'b0, m[W-1:0]};
        end
        if (m > maxn) return {1'b1, 1'b1, {(W-1){1'b0}}};
        return {1'b0, ~m[W-1:0] + 1'b1};
    endfunction

    assign shifted   = {rem[W-1:0], num[NW-1]};
    assign ge        = shifted >= {1'b0, dvs};
    assign diff      = shifted - {1'b0, dvs};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            num         <= '0;
            qacc        <= '0;
            rem         <= '0;
            dvs         <= '0;
            neg         <= 1'b0;
            dz          <= 1'b0;
            dvd_neg     <= 1'b0;
            quotient    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        num     <= {mag(dividend), {Q{1'b0}}};
                        dvs     <= mag(divisor);
                        neg     <= dividend[W-1] ^ divisor[W-1];
                        dvd_neg <= dividend[W-1];
                        dz      <= (divisor == '0);
                        rem     <= '0;
                        qacc    <= '0;
                        cnt     <= CW'(NW);
                        state   <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    rem  <= ge ? diff : shifted;
                    qacc <= {qacc[NW-2:0], ge};
                    num  <= num << 1;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (dz) begin
                        quotient    <= dvd_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else begin
                        {overflow, quotient} <= saturate(neg, qacc);
                        div_by_zero          <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider at M=7, Q=8 with an arithmetic reference model
// and a scoreboard checking every valid output cycle.
module tb_fixed_point_divider;
    localparam int W = 16;
    localparam int Q = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic         overflow;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;
    logic [17:0] expq[$];

    fixed_point_divider #(.M(7), .Q(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .overflow(overflow),
        .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact rational quotient, truncated toward zero, then clamped.
    function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint qq;
        logic [W-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return {1'b0, 1'b1, (sa >= 0) ? 16'h7FFF : 16'h8000};
        qq = (sa * (64'sd1 <<< Q)) / sb;
        if (qq > 32767)  return {1'b1, 1'b0, 16'h7FFF};
        if (qq < -32768) return {1'b1, 1'b0, 16'h8000};
        r = qq[W-1:0];
        return {1'b0, 1'b0, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
            if (in_valid && in_ready) expq.push_back(model(dividend, divisor));
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result quotient=%h with no accepted operation", quotient);
            end else begin
                chk("quotient", 32'(quotient), 32'(expq[0][15:0]));
                chk("overflow", 32'(overflow), 32'(expq[0][17]));
                chk("div_by_zero", 32'(div_by_zero), 32'(expq[0][16]));
            end
        end
    end

    // Call just after a negedge; returns just after the negedge following the accept edge.
    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", 32'(waited < 200), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic wait_out(input int exp_lat, input string nm);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk(nm, 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_handshake_valid", 32'(out_valid), 32'd0);
        chk("post_handshake_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        int w;
        accept_op(a, b, w);
        wait_out(lat, "latency");
        finish_out();
    endtask

    initial begin
        int w;
        logic [W-1:0] snap;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_flags", 32'({overflow, div_by_zero}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        chk("model_3_div_2", 32'(model(16'h0300, 16'h0200)), 32'h00180);
        chk("model_neg", 32'(model(16'hF880, 16'h0200)), 32'h0FC40);
        chk("model_1_div_3", 32'(model(16'h0100, 16'h0300)), 32'h00055);
        chk("model_trunc", 32'(model(16'hFF00, 16'h0300)), 32'h0FFAB);
        chk("model_ovf", 32'(model(16'h8000, 16'hFF00)), 32'h27FFF);
        chk("model_dz_neg", 32'(model(16'hFF00, 16'h0000)), 32'h18000);

        run_op(16'h0300, 16'h0200, 25);
        run_op(16'hF880, 16'h0200, 25);
        run_op(16'h0100, 16'h0300, 25);
        run_op(16'hFF00, 16'h0300, 25);
        run_op(16'h6400, 16'h0080, 25);
        run_op(16'h8000, 16'hFF00, 25);
        run_op(16'h8000, 16'h0100, 25);
        run_op(16'h0100, 16'h0000, 1);
        run_op(16'hFF00, 16'h0000, 1);
        run_op(16'h0000, 16'h0000, 1);

        // Backpressure: result must hold while the consumer stalls.
        accept_op(16'h0500, 16'h0200, w);
        wait_out(25, "latency_bp");
        snap = quotient;
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_stable", 32'(quotient), 32'(snap));
        end
        finish_out();

        // An in_valid pulse mid-calculation must be ignored.
        accept_op(16'h0A00, 16'h0300, w);
        repeat (5) @(negedge clk);
        in_valid = 1'b1; dividend = 16'h0100; divisor = 16'h0100;
        chk("calc_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(19, "latency_pulse");
        chk("pulse_queue", 32'(expq.size()), 32'd1);

        // Back-to-back: next operation waits only for the handshake edge.
        out_ready = 1'b1;
        accept_op(16'hFF00, 16'h0200, w);
        out_ready = 1'b0;
        chk("b2b_wait", 32'(w), 32'd1);
        wait_out(25, "latency_b2b");
        finish_out();

        // Asynchronous reset in the middle of a calculation.
        accept_op(16'h0300, 16'h0200, w);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_quotient", 32'(quotient), 32'd0);
        chk("arst_flags", 32'({overflow, div_by_zero}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            chk("arst_no_result", 32'(out_valid), 32'd0);
        end
        run_op(16'h0100, 16'h0300, 25);

        // Consumer always ready: handshake completes on the first valid cycle.
        out_ready = 1'b1;
        accept_op(16'h0300, 16'h0200, w);
        wait_out(25, "latency_held");
        @(negedge clk);
        chk("held_ready_done", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fixed_point_divider.md
# fixed_point_divider

Sequential signed fixed-point divider, the inverse of the package's fixed-point multiply. It accepts a dividend and divisor in the same signed fixed-point format (M integer bits, Q fractional bits, one sign bit) over a valid/ready handshake. It computes the quotient in that format with a restoring shift-subtract loop at one bit per cycle, then returns it over a second valid/ready handshake. It sits between a producer and a consumer of fixed-point datapath values wherever a full division is needed, and handles one operation at a time.

## Interface
- M, default 7: integer bits, excluding sign.
- Q, default 8: fractional bits.
- W, derived as M+Q+1 (16 at defaults): total signed word width.
- clk  input  1: clock; all state changes on the rising edge.
- rst  input  1: asynchronous, active-high reset.
- in_valid  input  1: dividend/divisor valid.
- in_ready  output  1: divider idle and able to accept.
- dividend  input  W: signed fixed-point, two's complement, binary point Q bits from the LSB.
- divisor  input  W: same format as dividend.
- out_valid  output  1: result valid.
- out_ready  input  1: consumer accepts the result.
- quotient  output  W: signed fixed-point result, same format.
- overflow  output  1: quotient was saturated.
- div_by_zero  output  1: divisor was zero.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: capture |dividend| and |divisor| as W-bit magnitudes, so the most-negative value maps to 2^(W-1). Also capture sign = sign(dividend) XOR sign(divisor) and the zero-divisor check.
  - Nonzero divisor goes to CALC with counter=W+Q. Zero divisor goes straight to FIX.
- CALC
  - Restoring division of numerator N = |dividend|<<Q (W+Q bits) by |divisor|.
  - Remainder register is W+1 bits.
  - Each cycle: shift the next N bit (MSB first) into the remainder, then trial-subtract the divisor. If the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Counter decrements each cycle. When the counter reaches 0, go to FIX.
- FIX: register the outputs, then go to DONE.
  - The raw quotient is a W+Q-bit unsigned magnitude.
  - Apply sign; rounding is truncation toward zero.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
  - overflow=1 only if saturation occurred.
  - Zero divisor: quotient=2^(W-1)-1 if dividend>=0 (0/0 included), otherwise -2^(W-1). Set div_by_zero=1 and overflow=0.
- DONE
  - out_valid=1.
  - quotient, overflow and div_by_zero stay stable until out_ready. On out_ready, go to IDLE.
- Input values changing after the accept edge have no effect. out_ready while out_valid=0 is ignored.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, overflow=0, div_by_zero=0. Counter and remainder are cleared.
- Reset mid-CALC or mid-DONE aborts the operation immediately; no result is produced.
- Latency, counting the accept edge as edge 0:
  - Nonzero divisor: CALC on edges 1..W+Q, FIX on edge W+Q+1, out_valid high after edge W+Q+1. At defaults, out_valid rises after edge 25.
  - Zero divisor: FIX on edge 1, out_valid high after edge 1.
- in_ready is low from the cycle after accept until the cycle after the out_ready handshake edge. No overlap between operations.
- Minimum spacing between accepts: W+Q+3 cycles for a nonzero divisor.
- A held out_ready (tied to 1) completes the handshake on the first out_valid cycle.
- Outputs are registered; there is no combinational path from inputs to outputs. in_ready is decoded from the state register.

## Test plan
All cases at M=7, Q=8.
- 0x0300 / 0x0200 (3.0/2.0) -> quotient 0x0180 (1.5), flags 0, out_valid after exactly 25 edges.
- 0xF880 / 0x0200 (-7.5/2.0) -> 0xFC40 (-3.75). 0x0100 / 0x0300 -> 0x0055. 0xFF00 / 0x0300 -> 0xFFAB (truncation toward zero).
- 0x6400 / 0x0080 (100/0.5) -> 0x7FFF, overflow=1. 0x8000 / 0xFF00 (-128/-1) -> 0x7FFF, overflow=1.
- Zero divisor:
  - 0x0100 / 0 -> 0x7FFF, div_by_zero=1, out_valid after edge 1.
  - 0xFF00 / 0 -> 0x8000.
  - 0 / 0 -> 0x7FFF.
- Backpressure and accept blocking:
  - Hold out_ready=0 for 10 cycles in DONE: outputs stable, in_ready=0.
  - in_valid pulsed during CALC is not accepted.
  - A back-to-back second operation is accepted on the cycle after the handshake and gives the correct result.
- Reset asserted asynchronously mid-CALC: all outputs go to reset values immediately. A new operation after release completes correctly.
